// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and an
// optional 2-entry skid buffer that registers in_ready to cut the upstream ready path.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W       = 96,
  parameter bit                SKID_EN      = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the live-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q;
  logic              acc, pop;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = 2'(state);
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_next   = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc && SKID_EN) begin
          state_next = SKID;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          state_next     = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // An accept or pop in the flush cycle is simply absorbed.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= BUBBLE_VALUE;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != SKID);
      if (flush)               main_q <= BUBBLE_VALUE;
      else if (load_main_in)   main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
    end
  end

  // NOTE: the skid payload is never observed unless the state says it is live, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-entry instance, checked every
// cycle against a FIFO-level model, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam int          W      = 32;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic                 clk = 1'b0;
  logic [1:0]           rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0][W-1:0]    in_data, out_data;
  logic [1:0][1:0]      occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Index 0: skid buffer enabled; index 1: single entry.
  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b1), .BUBBLE_VALUE(BUBBLE)) dut_skid (
    .clk(clk), .rst(rst[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0])
  );

  pipe_stage_reg #(.DATA_W(W), .SKID_EN(1'b0), .BUBBLE_VALUE(BUBBLE)) dut_single (
    .clk(clk), .rst(rst[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO with capacity 2 (skid) or 1 (single), plus last delivered word.
  logic [W-1:0] m_fifo [2][2];
  int           m_cnt  [2];
  logic [W-1:0] m_last [2];
  bit           m_live [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_live[d] = 1'b0;
      m_last[d] = BUBBLE;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic exp_ready;
        exp_ready = (d == 0) ? (m_cnt[d] < 2) : (m_cnt[d] == 0 || out_ready[d] == 1'b1);
        if (m_live[d]) begin
          check($sformatf("model_out_valid[%0d]", d), 32'(out_valid[d]), 32'(m_cnt[d] > 0));
          check($sformatf("model_out_data[%0d]", d), out_data[d],
                (m_cnt[d] > 0) ? m_fifo[d][0] : m_last[d]);
          check($sformatf("model_occupancy[%0d]", d), 32'(occupancy[d]), 32'(m_cnt[d]));
          check($sformatf("model_in_ready[%0d]", d), 32'(in_ready[d]), 32'(exp_ready));
        end
        if (rst[d]) begin
          m_cnt[d]  = 0;
          m_last[d] = BUBBLE;
          m_live[d] = 1'b1;
        end else if (m_live[d]) begin
          if (flush[d]) begin
            m_cnt[d]  = 0;
            m_last[d] = BUBBLE;
          end else begin
            if (m_cnt[d] > 0 && out_ready[d]) begin
              m_last[d]    = m_fifo[d][0];
              m_fifo[d][0] = m_fifo[d][1];
              m_cnt[d]--;
            end
            if (in_valid[d] && exp_ready) begin
              m_fifo[d][m_cnt[d]] = in_data[d];
              m_cnt[d]++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 2'b11; flush = '0; in_valid = '0; out_ready = '0; in_data = '0;
    step();
    step();
    rst = 2'b00;
    check("reset_in_ready", 32'(in_ready[0]), 32'd1);
    check("reset_out_valid", 32'(out_valid[0]), 32'd0);
    check("reset_occupancy", 32'(occupancy[0]), 32'd0);
    check("reset_out_data", out_data[0], BUBBLE);

    // Stream 0x11..0x14 at full rate.
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h11 + 32'(i);
      step();
      check("stream_valid", 32'(out_valid[0]), 32'd1);
      check("stream_data", out_data[0], 32'h11 + 32'(i));
      check("stream_occ", 32'(occupancy[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    step();
    check("drain_valid", 32'(out_valid[0]), 32'd0);
    check("drain_keeps_data", out_data[0], 32'h14);

    // Fill skid with back-pressure, then drain.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 32'hA;
    step();
    in_data[0] = 32'hB;
    step();
    in_valid[0] = 1'b0;
    check("skid_in_ready", 32'(in_ready[0]), 32'd0);
    check("skid_occ", 32'(occupancy[0]), 32'd2);
    out_ready[0] = 1'b1;
    #1;
    check("skid_first_out", out_data[0], 32'hA);
    step();
    check("skid_second_out", out_data[0], 32'hB);
    check("skid_second_occ", 32'(occupancy[0]), 32'd1);
    step();
    check("skid_drained", 32'(out_valid[0]), 32'd0);

    // Stall hold for 5 cycles.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 32'h55;
    step();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(out_valid[0]), 32'd1);
      check("hold_data", out_data[0], 32'h55);
    end

    // Flush while two entries are held and in_valid is up.
    in_valid[0] = 1'b1; in_data[0] = 32'h66;
    step();
    check("pre_flush_occ", 32'(occupancy[0]), 32'd2);
    flush[0] = 1'b1; in_data[0] = 32'hC;
    step();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    check("flush_valid", 32'(out_valid[0]), 32'd0);
    check("flush_data", out_data[0], BUBBLE);
    check("flush_occ", 32'(occupancy[0]), 32'd0);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_ghost", 32'(out_valid[0]), 32'd0);
    end

    // Reset with two entries held.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = 32'h71;
    step();
    in_data[0] = 32'h72;
    step();
    in_valid[0] = 1'b0;
    check("pre_rst_occ", 32'(occupancy[0]), 32'd2);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_occ", 32'(occupancy[0]), 32'd0);
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Single-entry instance: in_ready follows out_ready once full.
    out_ready[1] = 1'b1;
    in_valid[1] = 1'b1; in_data[1] = 32'h21;
    step();
    check("single_valid", 32'(out_valid[1]), 32'd1);
    check("single_ready_hi", 32'(in_ready[1]), 32'd1);
    out_ready[1] = 1'b0; in_data[1] = 32'h22;
    #1;
    check("single_ready_lo", 32'(in_ready[1]), 32'd0);
    step();
    check("single_hold", out_data[1], 32'h21);
    check("single_occ", 32'(occupancy[1]), 32'd1);
    out_ready[1] = 1'b1;
    #1;
    check("single_ready_back", 32'(in_ready[1]), 32'd1);
    step();
    check("single_next", out_data[1], 32'h22);
    in_valid[1] = 1'b0;
    step();

    // Randomized traffic on both instances, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        out_ready[d] = ($urandom_range(0, 2) != 0);
        flush[d]     = ($urandom_range(0, 40) == 0);
        rst[d]       = ($urandom_range(0, 250) == 0);
        in_data[d]   = $urandom;
      end
      step();
    end
    rst = '0; flush = '0; in_valid = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
